// File: rtl/sv8k_upload_pkg.sv
// Shared types and constants for the HPS RAM upload (save/RAM dump) read path.
package sv8k_upload_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PAUSE = 3'd1,
        READY = 3'd2,
        FETCH = 3'd3,
        HOLD  = 3'd4
    } state_t;

    localparam logic [7:0] FILL_DEFAULT   = 8'hFF;
    localparam int         RD_LAT_DEFAULT = 1;

    // ioctl_index value hps_io reports for the system RAM upload slot.
    localparam logic [7:0] IOCTL_INDEX_RAM = 8'h02;

    function automatic logic addr_in_range(input logic [24:0] addr, input logic [24:0] size);
        return addr < size;
    endfunction

endpackage

// File: rtl/ram_upload_reader_if.sv
// ioctl read-side bus between hps_io (master) and the RAM upload reader (slave).
interface ram_upload_reader_if;
    // ioctl_rd is a one-cycle request; ioctl_wait rises the cycle after it and the
    // byte on ioctl_din is valid in the first cycle ioctl_wait is low again.
    logic        ioctl_upload;
    logic        ioctl_rd;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;

    modport master (
        output ioctl_upload, ioctl_rd, ioctl_addr,
        input  ioctl_din, ioctl_wait
    );

    modport slave (
        input  ioctl_upload, ioctl_rd, ioctl_addr,
        output ioctl_din, ioctl_wait
    );
endinterface

// File: rtl/upload_edge_sync.sv
// Registered rise/fall detector for the ioctl_upload session flag.
module upload_edge_sync (
    input  logic clk_sys,
    input  logic reset,
    input  logic level,
    output logic rise,
    output logic fall
);
    logic level_q;

    // Resets high so a session still open across reset needs a fresh rising edge.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) level_q <= 1'b1;
        else       level_q <= level;
    end

    assign rise = level & ~level_q;
    assign fall = ~level & level_q;
endmodule

// File: rtl/ram_upload_reader.sv
// Reads system RAM back to hps_io during an upload; pauses the CPU and owns the RAM port.
// Optional UPLOAD_CSUM_EN adds upload_csum, a 16-bit running sum of delivered bytes.
module ram_upload_reader
    import sv8k_upload_pkg::*;
#(
    parameter int                ADDR_W = 16,
    parameter logic [ADDR_W-1:0] BASE   = '0,
    parameter logic [24:0]       SIZE   = 25'h10000,
    parameter int                RD_LAT = RD_LAT_DEFAULT,
    parameter logic [7:0]        FILL   = FILL_DEFAULT
) (
    input  logic              clk_sys,
    input  logic              reset,
    ram_upload_reader_if.slave bus,
    output logic              cpu_pause,
    input  logic              cpu_idle,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_rd,
    output logic              mem_sel,
    input  logic [7:0]        mem_q,
    output state_t            state_dbg
`ifdef UPLOAD_CSUM_EN
    ,
    output logic [15:0]       upload_csum
`endif
);
    logic rise, fall;

    upload_edge_sync u_edge (
        .clk_sys (clk_sys),
        .reset   (reset),
        .level   (bus.ioctl_upload),
        .rise    (rise),
        .fall    (fall)
    );

    state_t            state_q, state_n;
    logic              pause_q, pause_n;
    logic              sel_q, sel_n;
    logic              rd_q, rd_n;
    logic [ADDR_W-1:0] a_q, a_n;
    logic              wait_q, wait_n;
    logic [7:0]        din_q, din_n;
    logic              pend_q, pend_n;
    logic [24:0]       addr_q, addr_n;
    logic              oor_q, oor_n;
    logic [1:0]        cnt_q, cnt_n;
    logic              release_q, release_n;
    logic [24:0]       req_addr;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pause_q   <= 1'b0;
            sel_q     <= 1'b0;
            rd_q      <= 1'b0;
            a_q       <= '0;
            wait_q    <= 1'b0;
            din_q     <= 8'h00;
            pend_q    <= 1'b0;
            addr_q    <= '0;
            oor_q     <= 1'b0;
            cnt_q     <= 2'd0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_n;
            pause_q   <= pause_n;
            sel_q     <= sel_n;
            rd_q      <= rd_n;
            a_q       <= a_n;
            wait_q    <= wait_n;
            din_q     <= din_n;
            pend_q    <= pend_n;
            addr_q    <= addr_n;
            oor_q     <= oor_n;
            cnt_q     <= cnt_n;
            release_q <= release_n;
        end
    end

    always_comb begin
        state_n   = state_q;
        pause_n   = pause_q;
        sel_n     = sel_q;
        rd_n      = 1'b0;
        a_n       = a_q;
        wait_n    = wait_q;
        din_n     = din_q;
        pend_n    = pend_q;
        addr_n    = addr_q;
        oor_n     = oor_q;
        cnt_n     = cnt_q;
        release_n = release_q;
        req_addr  = pend_q ? addr_q : bus.ioctl_addr;

        // Session end wins over everything: release the port now, the CPU a cycle later.
        if (fall) begin
            state_n   = IDLE;
            sel_n     = 1'b0;
            wait_n    = 1'b0;
            pend_n    = 1'b0;
            release_n = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (release_q) begin
                        pause_n   = 1'b0;
                        release_n = 1'b0;
                    end
                    if (rise) begin
                        pause_n   = 1'b1;
                        release_n = 1'b0;
                        state_n   = PAUSE;
                    end
                end
                PAUSE: begin
                    if (bus.ioctl_rd && !pend_q) begin
                        pend_n = 1'b1;
                        addr_n = bus.ioctl_addr;
                        wait_n = 1'b1;
                    end
                    if (cpu_idle) begin
                        sel_n   = 1'b1;
                        state_n = READY;
                    end
                end
                READY: begin
                    if (bus.ioctl_rd || pend_q) begin
                        addr_n = req_addr;
                        pend_n = 1'b0;
                        wait_n = 1'b1;
                        if (addr_in_range(req_addr, SIZE)) begin
                            a_n     = BASE + req_addr[ADDR_W-1:0];
                            rd_n    = 1'b1;
                            cnt_n   = 2'd0;
                            oor_n   = 1'b0;
                            state_n = FETCH;
                        end else begin
                            oor_n   = 1'b1;
                            state_n = HOLD;
                        end
                    end
                end
                FETCH: begin
                    // Strobes here are protocol violations and are dropped.
                    if (cnt_q == 2'(RD_LAT - 1)) state_n = HOLD;
                    else                         cnt_n   = cnt_q + 2'd1;
                end
                HOLD: begin
                    din_n   = oor_q ? FILL : mem_q;
                    wait_n  = 1'b0;
                    state_n = READY;
                end
                default: state_n = IDLE;
            endcase
        end
    end

`ifdef UPLOAD_CSUM_EN
    logic [15:0] csum_q;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset)                         csum_q <= 16'h0000;
        else if (rise)                     csum_q <= 16'h0000;
        else if (state_q == HOLD && !fall) csum_q <= csum_q + {8'h00, din_n};
    end

    assign upload_csum = csum_q;
`endif

    assign bus.ioctl_din  = din_q;
    assign bus.ioctl_wait = wait_q;
    assign cpu_pause      = pause_q;
    assign mem_a          = a_q;
    assign mem_rd         = rd_q;
    assign mem_sel        = sel_q;
    assign state_dbg      = state_q;
endmodule

// File: tb/tb_ram_upload_reader.sv
// Scoreboard bench for ram_upload_reader with BASE=E000, SIZE=4000, RD_LAT=1.
module tb_ram_upload_reader;
    import sv8k_upload_pkg::*;

    logic        clk_sys  = 1'b0;
    logic        reset    = 1'b1;
    logic        cpu_idle = 1'b0;
    logic        cpu_pause, mem_rd, mem_sel;
    logic [15:0] mem_a;
    logic [7:0]  mem_q = 8'h00;
    state_t      state_dbg;
`ifdef UPLOAD_CSUM_EN
    logic [15:0] upload_csum;
`endif

    ram_upload_reader_if bus ();

    ram_upload_reader #(
        .ADDR_W (16),
        .BASE   (16'hE000),
        .SIZE   (25'h4000),
        .RD_LAT (1),
        .FILL   (8'hFF)
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .bus       (bus.slave),
        .cpu_pause (cpu_pause),
        .cpu_idle  (cpu_idle),
        .mem_a     (mem_a),
        .mem_rd    (mem_rd),
        .mem_sel   (mem_sel),
        .mem_q     (mem_q),
        .state_dbg (state_dbg)
`ifdef UPLOAD_CSUM_EN
        ,
        .upload_csum (upload_csum)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 clk_sys = ~clk_sys;

    // ---------------- RAM model: 1-cycle synchronous read ----------------
    function automatic logic [7:0] ram_byte(input logic [15:0] a);
        if (a == 16'hE000) return 8'h5A;
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    always @(posedge clk_sys) if (mem_rd) mem_q <= ram_byte(mem_a);

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    int   checks    = 0;
    int   failures  = 0;
    int   rd_pulses = 0;
    int   bad_rd    = 0;
    logic mon_en    = 1'b1;
    logic wait_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk_sys) begin
        logic [7:0] exp_v;
        if (mem_rd) rd_pulses++;
        if (mem_rd && !mem_sel) bad_rd++;
        if (mon_en && wait_prev && !bus.ioctl_wait) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_byte actual=%0h expected=none", bus.ioctl_din);
            end else begin
                exp_v = exp_q.pop_front();
                check("read_byte", {24'h0, bus.ioctl_din}, {24'h0, exp_v});
            end
        end
        wait_prev = bus.ioctl_wait;
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic strobe(input logic [24:0] a);
        tick(1);
        bus.ioctl_addr = a;
        bus.ioctl_rd   = 1'b1;
        tick(1);
        bus.ioctl_rd   = 1'b0;
    endtask

    task automatic wait_done(output int w);
        w = 0;
        @(negedge clk_sys);
        while (bus.ioctl_wait && w < 50) begin
            w++;
            @(negedge clk_sys);
        end
    endtask

    task automatic read_byte(input logic [24:0] a, input logic [7:0] exp, input int exp_w,
                             input string name);
        int w;
        exp_q.push_back(exp);
        strobe(a);
        wait_done(w);
        check(name, w, exp_w);
    endtask

    task automatic wait_sel(input string name);
        int n = 0;
        while (!mem_sel && n < 20) begin
            tick(1);
            n++;
        end
        check(name, {31'h0, mem_sel}, 32'h1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_din"},   {24'h0, bus.ioctl_din}, 32'h0);
        check({tag, "_wait"},  {31'h0, bus.ioctl_wait}, 32'h0);
        check({tag, "_pause"}, {31'h0, cpu_pause}, 32'h0);
        check({tag, "_mem_a"}, {16'h0, mem_a}, 32'h0);
        check({tag, "_mem_rd"}, {31'h0, mem_rd}, 32'h0);
        check({tag, "_mem_sel"}, {31'h0, mem_sel}, 32'h0);
        check({tag, "_state"}, 32'(state_dbg), 32'(IDLE));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int w;
        int snap;
        bus.ioctl_upload = 1'b0;
        bus.ioctl_rd     = 1'b0;
        bus.ioctl_addr   = '0;

        tick(2);
        @(negedge clk_sys);
        check_all_zero("reset");
        tick(1);
        reset = 1'b0;
        tick(2);

        // Read strobe outside a session is ignored.
        snap = rd_pulses;
        strobe(25'h0);
        @(negedge clk_sys);
        check("idle_rd_wait", {31'h0, bus.ioctl_wait}, 32'h0);
        tick(2);
        check("idle_rd_no_mem_rd", rd_pulses, snap);

        // Session 1: pause handshake with a read queued before the grant.
        bus.ioctl_upload = 1'b1;
        @(negedge clk_sys);
        check("pause_edge_cycle", {31'h0, cpu_pause}, 32'h0);
        tick(1);
        @(negedge clk_sys);
        check("pause_after_edge", {31'h0, cpu_pause}, 32'h1);
        check("state_pause", 32'(state_dbg), 32'(PAUSE));
        snap = rd_pulses;
        exp_q.push_back(8'hD9);
        strobe(25'h5);
        @(negedge clk_sys);
        check("pause_rd_wait", {31'h0, bus.ioctl_wait}, 32'h1);
        check("pause_sel_low", {31'h0, mem_sel}, 32'h0);
        tick(2);
        check("pause_no_mem_rd", rd_pulses, snap);
        cpu_idle = 1'b1;
        @(negedge clk_sys);
        check("sel_before_grant", {31'h0, mem_sel}, 32'h0);
        tick(1);
        @(negedge clk_sys);
        check("sel_after_grant", {31'h0, mem_sel}, 32'h1);
        wait_done(w);
        check("pend_wait_tail", w, 2);
        check("pend_one_mem_rd", rd_pulses, snap + 1);

        read_byte(25'h0000000, 8'h5A, 2, "wait_in_range");
        read_byte(25'h0003FFF, 8'hDC, 2, "wait_top");
        read_byte(25'h0002000, 8'h3C, 2, "wait_wrap");
        snap = rd_pulses;
        read_byte(25'h0004000, 8'hFF, 1, "wait_oor");
        read_byte(25'h1FFFFFF, 8'hFF, 1, "wait_oor_max");
        tick(1);
        check("oor_no_mem_rd", rd_pulses, snap);

        // Second strobe while in FETCH must be dropped.
        snap = rd_pulses;
        exp_q.push_back(8'h5A);
        tick(1);
        bus.ioctl_addr = 25'h0;
        bus.ioctl_rd   = 1'b1;
        tick(1);
        bus.ioctl_addr = 25'h4000;
        tick(1);
        bus.ioctl_rd   = 1'b0;
        wait_done(w);
        check("fetch_rd_wait", w, 1);
        tick(3);
        check("fetch_rd_one_mem_rd", rd_pulses, snap + 1);
        check("fetch_rd_queue_empty", exp_q.size(), 0);
`ifdef UPLOAD_CSUM_EN
        check("csum_session", {16'h0, upload_csum}, 32'h04A3);
`endif

        // Normal session end: port released first, CPU one cycle later.
        bus.ioctl_upload = 1'b0;
        tick(1);
        @(negedge clk_sys);
        check("end_sel", {31'h0, mem_sel}, 32'h0);
        check("end_pause_held", {31'h0, cpu_pause}, 32'h1);
        check("end_state", 32'(state_dbg), 32'(IDLE));
        tick(1);
        @(negedge clk_sys);
        check("end_pause_drop", {31'h0, cpu_pause}, 32'h0);
`ifdef UPLOAD_CSUM_EN
        check("csum_hold", {16'h0, upload_csum}, 32'h04A3);
`endif

        // Session 2: upload drops while the read is in FETCH.
        tick(1);
        bus.ioctl_upload = 1'b1;
        wait_sel("sel_session2");
        mon_en = 1'b0;
        tick(1);
        bus.ioctl_addr = 25'h0;
        bus.ioctl_rd   = 1'b1;
        tick(1);
        bus.ioctl_rd     = 1'b0;
        bus.ioctl_upload = 1'b0;
        @(negedge clk_sys);
        check("abort_in_fetch", 32'(state_dbg), 32'(FETCH));
        tick(1);
        @(negedge clk_sys);
        check("abort_sel", {31'h0, mem_sel}, 32'h0);
        check("abort_wait", {31'h0, bus.ioctl_wait}, 32'h0);
        check("abort_pause_held", {31'h0, cpu_pause}, 32'h1);
        check("abort_state", 32'(state_dbg), 32'(IDLE));
        tick(1);
        @(negedge clk_sys);
        check("abort_pause_drop", {31'h0, cpu_pause}, 32'h0);
        tick(1);
        mon_en = 1'b1;

        // Session 3: reset mid-read returns everything to reset values.
        bus.ioctl_upload = 1'b1;
        wait_sel("sel_session3");
        mon_en = 1'b0;
        tick(1);
        bus.ioctl_addr = 25'h0;
        bus.ioctl_rd   = 1'b1;
        tick(1);
        bus.ioctl_rd = 1'b0;
        reset        = 1'b1;
        #1;
        check_all_zero("midreset");
`ifdef UPLOAD_CSUM_EN
        check("csum_reset", {16'h0, upload_csum}, 32'h0);
`endif
        tick(2);
        reset = 1'b0;
        tick(5);
        check("no_restart_pause", {31'h0, cpu_pause}, 32'h0);
        check("no_restart_state", 32'(state_dbg), 32'(IDLE));
        mon_en = 1'b1;

        // Session 4: fresh edge after reset works again.
        bus.ioctl_upload = 1'b0;
        tick(2);
        bus.ioctl_upload = 1'b1;
        wait_sel("sel_session4");
        read_byte(25'h0, 8'h5A, 2, "wait_after_reset");
`ifdef UPLOAD_CSUM_EN
        check("csum_new_session", {16'h0, upload_csum}, 32'h005A);
`endif
        bus.ioctl_upload = 1'b0;
        tick(3);

        check("queue_drained", exp_q.size(), 0);
        check("mem_rd_without_sel", bad_rd, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ram_upload_reader.md
Name: ram_upload_reader

Overview:
- Read side of the HPS ioctl memory-transfer interface. Cartridge download writes RAM; this block reads system RAM back out when the HPS requests an upload (RAM/save dump).
- Sits between hps_io (ioctl_upload/ioctl_rd/ioctl_addr → ioctl_din) and the main 64 KiB dpram.
- Pauses the CPU for the whole transfer and owns the RAM port while paused.
- Stalls the HPS with ioctl_wait until each byte is valid.

Parameters:
ADDR_W, 16, RAM address width.
BASE, 16'h0000, RAM address mapped to ioctl_addr 0.
SIZE, 17'h10000, number of uploadable bytes; ioctl_addr >= SIZE is out of range.
RD_LAT, 1, RAM read latency in clk_sys cycles (1..3).
FILL, 8'hFF, byte returned for out-of-range addresses.

Ports:
clk_sys  in  1  system clock
reset  in  1  asynchronous, active-high reset
ioctl_upload  in  1  HPS upload session active
ioctl_rd  in  1  one-cycle read strobe from hps_io
ioctl_addr  in  25  byte address of the read
ioctl_din  out  8  byte returned to hps_io
ioctl_wait  out  1  stall the HPS; high from strobe until the byte is valid
cpu_pause  out  1  request CPU halt
cpu_idle  in  1  CPU halted and not driving RAM
mem_a  out  ADDR_W  RAM address; valid only while mem_sel = 1
mem_rd  out  1  RAM read strobe
mem_sel  out  1  RAM port mux select: 1 = this block owns the port

Behaviour:
- Reset values: ioctl_din = 0, ioctl_wait = 0, cpu_pause = 0, mem_a = 0, mem_rd = 0, mem_sel = 0, FSM = IDLE.
- FSM states: IDLE, PAUSE, READY, FETCH, HOLD.
- IDLE:
  - On ioctl_upload rising (registered edge detect): set cpu_pause = 1, go to PAUSE.
  - ioctl_rd in IDLE is ignored.
- PAUSE:
  - Hold cpu_pause.
  - When cpu_idle = 1: set mem_sel = 1, go to READY.
  - An ioctl_rd arriving here is latched (address and pending flag), ioctl_wait = 1 the next cycle, and the read is serviced on entry to READY.
- READY, on ioctl_rd (or latched pending read):
  - Register the address and assert ioctl_wait = 1 the cycle after the strobe.
  - In range (addr < SIZE): mem_a = BASE + addr[ADDR_W-1:0], truncated modulo 2^ADDR_W (wraps past FFFF); mem_rd = 1 for one cycle; go to FETCH.
  - Out of range: ioctl_din = FILL, go to HOLD with no RAM access.
- FETCH:
  - Count RD_LAT cycles after the mem_rd cycle, then capture the RAM q into ioctl_din and go to HOLD.
  - In-range strobe-to-valid latency = RD_LAT + 2 cycles.
- HOLD:
  - ioctl_din valid, ioctl_wait = 0, return to READY the same cycle.
  - ioctl_din holds its value until the next capture.
- An ioctl_rd arriving while in FETCH is a protocol violation: ignored, ioctl_wait stays high.
- ioctl_upload falling, any state:
  - Abort any in-flight read, drop mem_sel and ioctl_wait the next cycle, then drop cpu_pause one cycle later (port released before the CPU resumes). Go to IDLE.
- cpu_idle deasserting while mem_sel = 1: ignored; the pause remains requested.
- reset asserted mid-transfer: immediate return to reset values. No pending read survives. A new ioctl_upload edge is required to start again.
- mem_rd is never asserted when mem_sel = 0.

Optional Feature:
- Macro: UPLOAD_CSUM_EN.
- With the macro defined:
  - Extra output port upload_csum [15:0]: running 16-bit wrapping sum of every byte delivered in HOLD.
  - Cleared on ioctl_upload rising and on reset.
  - Holds its value after the session ends, for OSD/debug display.
- Without the macro: no port and no adder; behaviour otherwise identical.

Decomposition:
- Shared package sv8k_upload_pkg holds:
  - the state enum;
  - the FILL and RD_LAT default constants;
  - the ioctl index constant for the RAM upload slot.
- One natural sub-module: upload_edge_sync, a registered rise/fall detector on ioctl_upload.

Test Plan:
- Upload rises, cpu_idle is held low for 5 cycles then goes high → cpu_pause = 1 from the cycle after the edge; mem_sel rises the cycle after cpu_idle.
- RAM[C000] = 8'h5A, BASE = C000, read addr 0 → ioctl_wait high for exactly RD_LAT+1 cycles; ioctl_din = 8'h5A at strobe+RD_LAT+2.
- SIZE = 16'h2000, read addr 25'h2000 → ioctl_din = 8'hFF after 1 wait cycle; mem_rd never pulses.
- ioctl_rd issued during PAUSE, before cpu_idle → serviced after grant; correct byte returned; no earlier mem_rd.
- ioctl_upload drops during FETCH → mem_sel = 0 and ioctl_wait = 0 next cycle; cpu_pause = 0 one cycle later; FSM = IDLE.
- With UPLOAD_CSUM_EN, read bytes 8'hFF, 8'h02 → upload_csum = 16'h0101; reset asserted mid-read → all outputs 0.
